// File: rtl/fht_reorder_pkg.sv
// fht_reorder_pkg: FSM states, mode encodings and the bit-reverse helper
// shared by the bit-reversed to natural-order reorder engine.
package fht_reorder_pkg;

   typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} reorder_state_t;

   localparam logic MODE_SERIAL   = 1'b0;
   localparam logic MODE_PARALLEL = 1'b1;

   // Reverses the low a_bit bits of x; bits above a_bit come back as zero.
   function automatic logic [31:0] f_bit_rev(input logic [31:0] x, input int a_bit);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++)
         if (i < a_bit) r[a_bit - 1 - i] = x[i];
      return r;
   endfunction

endpackage

// File: rtl/fht_reorder_lane_reg.sv
// fht_reorder_lane_reg: N_BANK-lane capture register; with FHT_REORDER_SCALE_EN
// each lane is rounded half up and arithmetically shifted right by SHIFT on capture.
module fht_reorder_lane_reg #(
   parameter int D_BIT  = 18,
   parameter int N_BANK = 4,
   parameter int SHIFT  = 0
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic                    iLOAD,
   input  logic [N_BANK*D_BIT-1:0] iDATA,
   output logic [N_BANK*D_BIT-1:0] oDATA
);

   logic [N_BANK*D_BIT-1:0] scaled, lanes_d, lanes_q;

   if (SHIFT < 0 || SHIFT > D_BIT) begin : g_bad_shift
      $error("fht_reorder_lane_reg: SHIFT out of range");
   end

`ifdef FHT_REORDER_SCALE_EN
   localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [D_BIT:0] RND = (SHIFT > 0) ? (D_BIT + 1)'(1) <<< RS : '0;
   // One guard bit keeps the rounding add from overflowing before the shift.
   for (genvar k = 0; k < N_BANK; k++) begin : g_lane
      logic signed [D_BIT:0] sum;
      assign sum = $signed({iDATA[k*D_BIT + D_BIT - 1], iDATA[k*D_BIT +: D_BIT]}) + RND;
      assign scaled[k*D_BIT +: D_BIT] = D_BIT'(sum >>> SHIFT);
   end
`else
   assign scaled = iDATA;
`endif

   always_comb begin
      lanes_d = iLOAD ? scaled : lanes_q;
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) lanes_q <= '0;
      else        lanes_q <= lanes_d;
   end

   assign oDATA = lanes_q;

endmodule

// File: rtl/fht_bitrev_reorder.sv
// fht_bitrev_reorder: reads an FHT result in bit-reversed order and rewrites it in
// natural order, serially per bank or all banks at once. Optional FHT_REORDER_SCALE_EN.
module fht_bitrev_reorder
   import fht_reorder_pkg::*;
#(
   parameter int D_BIT  = 18,
   parameter int A_BIT  = 8,
   parameter int N_BANK = 4,
   parameter int RD_LAT = 1,
   parameter int SHIFT  = 0
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic                    iSTART,
   input  logic                    iMODE,
   output logic [A_BIT-1:0]        oADDR_RD,
   input  logic [N_BANK*D_BIT-1:0] iDATA,
   output logic [A_BIT-1:0]        oADDR_WR,
   output logic [N_BANK*D_BIT-1:0] oDATA,
   output logic [N_BANK-1:0]       oWE,
   output logic                    oBUSY,
   output logic                    oRDY
);

   localparam int WW = $clog2(RD_LAT + 1);
   localparam int BW = (N_BANK > 1) ? $clog2(N_BANK) : 1;
   localparam logic [A_BIT-1:0] LAST = '1;

   reorder_state_t   state_d, state_q;
   logic             mode_d, mode_q;
   logic [A_BIT-1:0] cnt_d, cnt_q, addr_wr_d, addr_wr_q;
   logic [WW-1:0]    wait_d, wait_q;
   logic [BW-1:0]    bank_d, bank_q;
   logic             load, wr_last;

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      addr_wr_d = addr_wr_q;
      wait_d    = wait_q;
      bank_d    = bank_q;
      load      = 1'b0;
      wr_last   = (mode_q == MODE_PARALLEL) || (bank_q == BW'(N_BANK - 1));
      case (state_q)
         IDLE: if (iSTART) begin
            state_d = RD_WAIT;
            mode_d  = iMODE;
            cnt_d   = '0;
            wait_d  = '0;
         end
         // The last wait cycle is the one in which the source data is valid.
         RD_WAIT: if (wait_q == WW'(RD_LAT - 1)) begin
            load      = 1'b1;
            addr_wr_d = cnt_q;
            bank_d    = '0;
            state_d   = WRITE;
         end else begin
            wait_d = wait_q + 1'b1;
         end
         WRITE: if (!wr_last) begin
            bank_d = bank_q + 1'b1;
         end else if (cnt_q == LAST) begin
            state_d = DONE;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            wait_d  = '0;
            state_d = RD_WAIT;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         state_q   <= IDLE;
         mode_q    <= MODE_SERIAL;
         cnt_q     <= '0;
         addr_wr_q <= '0;
         wait_q    <= '0;
         bank_q    <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         addr_wr_q <= addr_wr_d;
         wait_q    <= wait_d;
         bank_q    <= bank_d;
      end
   end

   fht_reorder_lane_reg #(
      .D_BIT  (D_BIT),
      .N_BANK (N_BANK),
      .SHIFT  (SHIFT)
   ) u_lane_reg (
      .iCLK   (iCLK),
      .iRESET (iRESET),
      .iLOAD  (load),
      .iDATA  (iDATA),
      .oDATA  (oDATA)
   );

   assign oADDR_RD = A_BIT'(f_bit_rev(32'(cnt_q), A_BIT));
   assign oADDR_WR = addr_wr_q;
   assign oWE      = (state_q != WRITE) ? '0 :
                     (mode_q == MODE_PARALLEL) ? '1 : N_BANK'(1) << bank_q;
   assign oBUSY    = (state_q == RD_WAIT) || (state_q == WRITE);
   assign oRDY     = (state_q == DONE);

endmodule

// File: tb/tb_fht_bitrev_reorder.sv
// tb_fht_bitrev_reorder: scoreboard bench for fht_bitrev_reorder, one instance with
// RD_LAT=1 and one with RD_LAT=3; source word at bank b, address a is base+16b+a.
module tb_fht_bitrev_reorder;

   localparam int D_BIT  = 18;
   localparam int A_BIT  = 3;
   localparam int N_BANK = 4;
   localparam int DEPTH  = 1 << A_BIT;
   localparam int SHIFT  = 3;
   localparam int W      = N_BANK * D_BIT;

   typedef struct {
      logic [A_BIT-1:0]  addr;
      logic [N_BANK-1:0] we;
      logic [W-1:0]      data;
   } wr_t;

   logic clk = 1'b0;
   logic iRESET, iSTART, iMODE, start3;
   logic [A_BIT-1:0] addr_rd, addr_wr, addr_rd3, addr_wr3, rd3_d1, rd3_d2;
   logic [W-1:0] idata, odata, idata3, data3;
   logic [N_BANK-1:0] we, we3;
   logic busy, rdy, busy3, rdy3;
   int base = 0;
   int n_chk = 0;
   int n_fail = 0;
   int w3 = 0;
   int rw3 = 0;
   wr_t sbq[$];
   wr_t mon_e;

   always #5 clk = ~clk;

   function automatic int brev(input int a);
      int r = 0;
      for (int i = 0; i < A_BIT; i++) r |= ((a >> i) & 1) << (A_BIT - 1 - i);
      return r;
   endfunction

   function automatic logic [D_BIT-1:0] exp_lane(input int v);
`ifdef FHT_REORDER_SCALE_EN
      int r;
      r = v;
      if (SHIFT > 0) r = r + (1 << (SHIFT - 1));
      return D_BIT'(r >>> SHIFT);
`else
      return D_BIT'(v);
`endif
   endfunction

   function automatic logic [W-1:0] src_word(input logic [A_BIT-1:0] a, input int bs);
      logic [W-1:0] w;
      for (int b = 0; b < N_BANK; b++) w[b*D_BIT +: D_BIT] = D_BIT'(bs + 16 * b + int'(a));
      return w;
   endfunction

   function automatic logic [W-1:0] exp_word(input int a, input int bs);
      logic [W-1:0] w;
      for (int b = 0; b < N_BANK; b++) w[b*D_BIT +: D_BIT] = exp_lane(bs + 16 * b + brev(a));
      return w;
   endfunction

   // RD_LAT=1 source reads combinationally; RD_LAT=3 source delays the address two edges.
   assign idata  = src_word(addr_rd, base);
   assign idata3 = src_word(rd3_d2, base);
   always @(posedge clk) begin
      rd3_d1 <= addr_rd3;
      rd3_d2 <= rd3_d1;
   end

   fht_bitrev_reorder #(
      .D_BIT(D_BIT), .A_BIT(A_BIT), .N_BANK(N_BANK), .RD_LAT(1), .SHIFT(SHIFT)
   ) u_dut (
      .iCLK(clk), .iRESET(iRESET), .iSTART(iSTART), .iMODE(iMODE),
      .oADDR_RD(addr_rd), .iDATA(idata), .oADDR_WR(addr_wr), .oDATA(odata),
      .oWE(we), .oBUSY(busy), .oRDY(rdy)
   );

   fht_bitrev_reorder #(
      .D_BIT(D_BIT), .A_BIT(A_BIT), .N_BANK(N_BANK), .RD_LAT(3), .SHIFT(SHIFT)
   ) u_dut3 (
      .iCLK(clk), .iRESET(iRESET), .iSTART(start3), .iMODE(1'b1),
      .oADDR_RD(addr_rd3), .iDATA(idata3), .oADDR_WR(addr_wr3), .oDATA(data3),
      .oWE(we3), .oBUSY(busy3), .oRDY(rdy3)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_addr_rd"}, W'(addr_rd), '0);
      check({tag, "_addr_wr"}, W'(addr_wr), '0);
      check({tag, "_data"}, odata, '0);
      check({tag, "_we"}, W'(we), '0);
      check({tag, "_busy"}, W'(busy), '0);
      check({tag, "_rdy"}, W'(rdy), '0);
   endtask

   task automatic push_run(input logic mode);
      wr_t e;
      for (int a = 0; a < DEPTH; a++)
         for (int k = 0; k < (mode ? 1 : N_BANK); k++) begin
            e.addr = A_BIT'(a);
            e.we   = mode ? '1 : N_BANK'(1 << k);
            e.data = exp_word(a, base);
            sbq.push_back(e);
         end
   endtask

   always @(negedge clk) begin
      if (we != '0) begin
         if (sbq.size() == 0) check("unexpected_we", W'(we), '0);
         else begin
            mon_e = sbq.pop_front();
            check("addr_wr", W'(addr_wr), W'(mon_e.addr));
            check("we", W'(we), W'(mon_e.we));
            check("data", odata, mon_e.data);
         end
      end
   end

   always @(negedge clk) begin
      if (we3 != '0) begin
         check("addr_wr3", W'(addr_wr3), W'(w3));
         check("we3", W'(we3), W'(4'hF));
         check("data3", data3, exp_word(w3, base));
         w3++;
      end else if (busy3) begin
         check("rd_hold3", W'(addr_rd3), W'(brev(w3)));
         rw3++;
      end
   end

   task automatic run(input string tag, input logic mode, input int exp_lat,
                      input int pulse_at, input int reset_at, input bit done_pulse);
      int lat;
      int extra;
      lat = 0;
      @(negedge clk);
      iMODE = mode;
      iSTART = 1'b1;
      push_run(mode);
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         iSTART = (k == pulse_at);
         if (k == 1) check({tag, "_busy"}, W'(busy), W'(1));
         if (k == reset_at) begin
            iRESET = 1'b1;
            @(negedge clk);
            chk_idle({tag, "_abort"});
            iRESET = 1'b0;
            sbq.delete();
            return;
         end
         if (rdy) begin
            lat = k;
            break;
         end
      end
      check({tag, "_lat"}, W'(lat), W'(exp_lat));
      iSTART = done_pulse;
      @(negedge clk);
      iSTART = 1'b0;
      check({tag, "_rdy_pulse"}, W'(rdy), '0);
      check({tag, "_idle_busy"}, W'(busy), '0);
      @(negedge clk);
      check({tag, "_still_idle"}, W'(busy), '0);
      check({tag, "_sb_empty"}, W'(sbq.size()), '0);
      if (pulse_at > 0) begin
         extra = 0;
         repeat (45) begin
            @(negedge clk);
            if (rdy) extra++;
         end
         check({tag, "_extra_rdy"}, W'(extra), '0);
      end
   endtask

   task automatic run3(input int exp_lat);
      int lat;
      lat = 0;
      w3 = 0;
      rw3 = 0;
      @(negedge clk);
      start3 = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         start3 = 1'b0;
         if (rdy3) begin
            lat = k;
            break;
         end
      end
      check("lat3", W'(lat), W'(exp_lat));
      check("writes3", W'(w3), W'(DEPTH));
      check("rd_wait3", W'(rw3), W'(3 * DEPTH));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      iRESET = 1'b1;
      iSTART = 1'b0;
      iMODE  = 1'b0;
      start3 = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle("rst");
      check("rst_busy3", W'(busy3), '0);
      check("rst_we3", W'(we3), '0);
      iRESET = 1'b0;
      run("serial", 1'b0, 41, 0, 0, 1'b0);
      run("parallel", 1'b1, 17, 0, 0, 1'b1);
      run("restart_ignored", 1'b0, 41, 10, 0, 1'b0);
      run("abort", 1'b0, 41, 0, 12, 1'b0);
      run("after_abort", 1'b0, 41, 0, 0, 1'b0);
      base = -13;
      run("signed_par", 1'b1, 17, 0, 0, 1'b0);
      run("signed_ser", 1'b0, 41, 0, 0, 1'b0);
      base = 0;
      run3(33);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fht_bitrev_reorder.md
Name: fht_bitrev_reorder

Overview:
- Hardware engine that turns a finished FHT result (N_BANK banks, bit-reversed address order) into natural order and writes it into the write ports of a downstream FHT/IFHT instance.
- Replaces the bench-side buffer-and-rewrite step that sits between the forward and inverse transform.
- Reads the source RAM through its read-address port and drives the destination's iWE/iDATA_*/iADDR_WR_* ports, one word per bank for each address.
- Supports serial per-bank writes or parallel all-bank writes.

Parameters:
- D_BIT, 18, data word width (fixed point, same format as the FHT RAM).
- A_BIT, 8, bank address width; bank depth is 2**A_BIT.
- N_BANK, 4, number of banks or lanes (≥1).
- RD_LAT, 1, source RAM read latency in cycles (≥1).
- SHIFT, 0, arithmetic right shift applied when SCALE is compiled in.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  synchronous, active-high reset.
- iSTART  in  1  one-cycle start pulse; ignored while oBUSY=1.
- iMODE  in  1  sampled at start: 0 = serial writes (one oWE bit per cycle), 1 = parallel writes (all oWE bits together).
- oADDR_RD  out  A_BIT  read address to all source banks.
- iDATA  in  N_BANK*D_BIT  source read data; lane k is bits [k*D_BIT +: D_BIT].
- oADDR_WR  out  A_BIT  destination write address (natural order).
- oDATA  out  N_BANK*D_BIT  destination write data, one lane per bank.
- oWE  out  N_BANK  destination write enables, bit k is bank k.
- oBUSY  out  1  high from the cycle after an accepted start until DONE.
- oRDY  out  1  one-cycle pulse when the last write has been issued.

Behaviour:
- Reset: all outputs are 0, FSM returns to IDLE, counter cnt is 0, and the latched mode is 0. Reset mid-operation aborts immediately; no further oWE is asserted.
- FSM states: IDLE, RD_WAIT, WRITE, DONE.
- IDLE:
  - iSTART=1 latches iMODE.
  - Sets cnt=0 and oADDR_RD=bitrev(0).
  - Goes to RD_WAIT and raises oBUSY.
- RD_WAIT:
  - oADDR_RD = bitrev(cnt) is held for RD_LAT cycles.
  - On the cycle iDATA is valid, all lanes are captured into a lane register; go to WRITE.
- WRITE, serial mode:
  - N_BANK cycles; cycle k asserts only oWE[k].
  - oADDR_WR = cnt; oDATA holds the captured lanes, stable for the whole phase.
- WRITE, parallel mode:
  - One cycle with oWE = all ones.
- End of WRITE:
  - If cnt = 2**A_BIT−1, go to DONE.
  - Otherwise cnt+1, oADDR_RD = bitrev(cnt+1), go to RD_WAIT.
- DONE: oRDY=1 for one cycle, oBUSY=0, return to IDLE. A start pulse in the DONE cycle is ignored.
- bitrev(x): bit i of x maps to bit A_BIT−1−i.
- Cycles per address:
  - serial: RD_LAT + N_BANK;
  - parallel: RD_LAT + 1.
- Total latency from the start pulse to oRDY = 2**A_BIT × (cycles per address) + 1.
- oWE is 0 in every state except WRITE. oADDR_WR and oDATA hold their last value outside WRITE.
- cnt never wraps during an operation; the terminal check is taken before the increment.

Optional Feature:
- Macro: FHT_REORDER_SCALE_EN.
- Defined:
  - each captured lane becomes (x + 2**(SHIFT−1)) >>> SHIFT, signed, round half up, then truncated back to D_BIT;
  - SHIFT=0 passes data unchanged;
  - used for the IFHT 1/N normalisation.
- Undefined: lanes are passed bit-exact and SHIFT is ignored.
- Latency is identical in both builds.

Decomposition:
- Shared package fht_reorder_pkg holds:
  - FSM state enum reorder_state_t;
  - mode constants MODE_SERIAL and MODE_PARALLEL;
  - function f_bit_rev(A_BIT).
- One natural sub-module, fht_reorder_lane_reg: an N_BANK-lane capture register, with the optional scaling inside each lane.

Test Plan:
Common setup: A_BIT=3, N_BANK=4, RD_LAT=1, source bank b at address a holds 16b+a.
1. Serial mode, start → 40 write cycles, then oRDY one cycle later, 41 cycles after start. Address 1 receives read address 4: lanes 4, 20, 36, 52. oWE sequence per address is 0001, 0010, 0100, 1000.
2. Parallel mode → oRDY 17 cycles after start; oWE=1111 for each oADDR_WR from 0 to 7. Address 6 receives source address 3 (lanes 3, 19, 35, 51).
3. iSTART pulsed again at cycle 10 of a serial run → ignored; the run ends normally with exactly one oRDY.
4. iRESET asserted at cycle 12 → the next cycle shows all outputs 0 and state IDLE. A new start then completes a full 41-cycle run.
5. FHT_REORDER_SCALE_EN, SHIFT=3, source lanes 20 and −13 → written values 3 and −2.
6. RD_LAT=3, parallel mode → oRDY 8×4+1 = 33 cycles after start. oADDR_RD is held stable for 3 cycles per address.
